// File: rtl/formation_ctl_if.sv
// -----------------------------------------------------------------------------
// formation_ctl_if
//   Control and position bundle between a formation controller and whoever
//   drives it (game sequencer, testbench) or consumes its position.
//
//   start      1-cycle pulse: begin moving (honoured only while idle)
//   restart    1-cycle pulse: reload start position and return to idle
//   en         1 = movement divider runs, 0 = pause
//   x_out      formation base x (11 bits)
//   y_out      formation base y (11 bits)
//   dir        1 = moving right, 0 = moving left
//   move_tick  1-cycle pulse on every edge where x_out or y_out changes
//   landed     high once the formation has reached the bottom limit
//
//   master: drives the controls and reads the position
//   slave : the controller itself
// -----------------------------------------------------------------------------
interface formation_ctl_if;
    logic        start;
    logic        restart;
    logic        en;
    logic [10:0] x_out;
    logic [10:0] y_out;
    logic        dir;
    logic        move_tick;
    logic        landed;

    modport master (
        output start, restart, en,
        input  x_out, y_out, dir, move_tick, landed
    );

    modport slave (
        input  start, restart, en,
        output x_out, y_out, dir, move_tick, landed
    );
endinterface

// File: rtl/formation_ctl.sv
// -----------------------------------------------------------------------------
// formation_ctl
//   Generates the base (x,y) of the enemy formation. The base steps sideways
//   once every TICK_DIV clocks, drops one row and reverses direction at each
//   screen edge, and stops for good once it reaches the bottom limit.
//   Downstream per-enemy blocks add their own column offsets to x_out/y_out.
//
//   Ports
//     pclk   in  pixel clock, single clock domain
//     rst_n  in  asynchronous active-low reset
//     bus    formation_ctl_if.slave
//              start, restart, en      in
//              x_out, y_out, dir,
//              move_tick, landed       out (all registered)
// -----------------------------------------------------------------------------
module formation_ctl #(
    parameter int unsigned X_START  = 100,
    parameter int unsigned Y_START  = 50,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 324,
    parameter int unsigned STEP_X   = 4,
    parameter int unsigned STEP_Y   = 20,
    parameter int unsigned Y_LIMIT  = 600,
    parameter int unsigned TICK_DIV = 650000
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    formation_ctl_if.slave        bus
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [10:0]      X_START_V = 11'(X_START);
    localparam logic [10:0]      Y_START_V = 11'(Y_START);

    // Position arithmetic is carried one bit wider than the outputs so that
    // every limit comparison happens before truncation and cannot wrap.
    localparam logic [11:0] X_MIN_W   = 12'(X_MIN);
    localparam logic [11:0] X_MAX_W   = 12'(X_MAX);
    localparam logic [11:0] STEP_X_W  = 12'(STEP_X);
    localparam logic [11:0] STEP_Y_W  = 12'(STEP_Y);
    localparam logic [11:0] Y_LIMIT_W = 12'(Y_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_H    = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_LANDED    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      x_q, x_d;
    logic [10:0]      y_q, y_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             landed_q, landed_d;

    logic [11:0] x_wide;
    logic [11:0] y_wide;
    logic        move_ev;

    assign x_wide = {1'b0, x_q};
    assign y_wide = {1'b0, y_q};

    // A move event is the last count of the divider while enabled; the
    // divider only runs in the two moving states.
    assign move_ev = ((state_q == ST_MOVE_H) || (state_q == ST_MOVE_DOWN))
                     && bus.en && (div_q == DIV_LAST);

    // NOTE: every output of this block is given a default before the case
    // statement, so no path leaves a variable unassigned and no latch forms.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        landed_d = landed_q;
        tick_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    state_d = ST_MOVE_H;
                end
            end

            ST_MOVE_H, ST_MOVE_DOWN: begin
                if (bus.en) begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                end
                if (move_ev && (state_q == ST_MOVE_H)) begin
                    if (dir_q) begin
                        if (x_wide + STEP_X_W >= X_MAX_W) begin
                            x_d     = X_MAX_W[10:0];
                            state_d = ST_MOVE_DOWN;
                        end else begin
                            x_d = 11'(x_wide + STEP_X_W);
                        end
                    end else begin
                        if (x_wide <= X_MIN_W + STEP_X_W) begin
                            x_d     = X_MIN_W[10:0];
                            state_d = ST_MOVE_DOWN;
                        end else begin
                            x_d = 11'(x_wide - STEP_X_W);
                        end
                    end
                end else if (move_ev) begin
                    dir_d = ~dir_q;
                    if (y_wide + STEP_Y_W >= Y_LIMIT_W) begin
                        y_d      = Y_LIMIT_W[10:0];
                        landed_d = 1'b1;
                        state_d  = ST_LANDED;
                    end else begin
                        y_d     = 11'(y_wide + STEP_Y_W);
                        state_d = ST_MOVE_H;
                    end
                end
                // Clamping onto a limit the base already sits on is not a move.
                tick_d = (x_d != x_q) || (y_d != y_q);
            end

            ST_LANDED: begin
                // Frozen until restart or reset.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restart outranks start and any coincident move event.
        if (bus.restart) begin
            state_d  = ST_IDLE;
            div_d    = '0;
            x_d      = X_START_V;
            y_d      = Y_START_V;
            dir_d    = 1'b1;
            landed_d = 1'b0;
            tick_d   = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            x_q      <= X_START_V;
            y_q      <= Y_START_V;
            dir_q    <= 1'b1;
            tick_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            tick_q   <= tick_d;
            landed_q <= landed_d;
        end
    end

    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.dir       = dir_q;
    assign bus.move_tick = tick_q;
    assign bus.landed    = landed_q;

endmodule

// File: tb/tb_formation_ctl.sv
// -----------------------------------------------------------------------------
// tb_formation_ctl
//   Self-checking bench for formation_ctl with a small playfield: directed
//   sequences (table of expected move events, pause, restart races, async
//   reset) followed by randomized control inputs compared against a
//   behavioural model of the formation.
// -----------------------------------------------------------------------------
module tb_formation_ctl;

    localparam int TD   = 4;
    localparam int XS   = 10;
    localparam int YS   = 0;
    localparam int XMIN = 0;
    localparam int XMAX = 20;
    localparam int SX   = 4;
    localparam int SY   = 5;
    localparam int YL   = 10;

    logic pclk;
    logic rst_n;

    formation_ctl_if bus ();

    formation_ctl #(
        .X_START (XS),
        .Y_START (YS),
        .X_MIN   (XMIN),
        .X_MAX   (XMAX),
        .STEP_X  (SX),
        .STEP_Y  (SY),
        .Y_LIMIT (YL),
        .TICK_DIV(TD)
    ) dut (
        .pclk (pclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The formation is either parked, marching, or landed. While marching it
    // owes one move every TD enabled clocks; a pending drop means the next
    // move is a row drop rather than a sideways step.
    int m_x, m_y, m_dir, m_tick, m_landed, m_running, m_drop, m_wait;

    task automatic model_reset();
        m_x = XS; m_y = YS; m_dir = 1; m_tick = 0;
        m_landed = 0; m_running = 0; m_drop = 0; m_wait = TD;
    endtask

    task automatic model_step(input logic s, input logic r, input logic e);
        int nx, ny, edge_x;
        m_tick = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (m_landed) return;
        if (m_running == 0) begin
            if (s) begin
                m_running = 1;
                m_wait    = TD;
            end
            return;
        end
        if (!e) return;
        m_wait--;
        if (m_wait != 0) return;
        m_wait = TD;
        if (m_drop == 0) begin
            if (m_dir != 0) begin
                nx     = (m_x + SX < XMAX) ? m_x + SX : XMAX;
                edge_x = XMAX;
            end else begin
                nx     = (m_x - SX > XMIN) ? m_x - SX : XMIN;
                edge_x = XMIN;
            end
            m_drop = (nx == edge_x) ? 1 : 0;
            m_tick = (nx != m_x) ? 1 : 0;
            m_x    = nx;
        end else begin
            ny     = (m_y + SY < YL) ? m_y + SY : YL;
            m_dir  = 1 - m_dir;
            m_drop = 0;
            m_tick = (ny != m_y) ? 1 : 0;
            m_y    = ny;
            if (ny == YL) begin
                m_landed  = 1;
                m_running = 0;
            end
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // sample the DUT 1 time unit after the edge.
    task automatic cycle();
        model_step(bus.start, bus.restart, bus.en);
        @(posedge pclk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".x"},      int'(bus.x_out),     m_x);
        check({tag, ".y"},      int'(bus.y_out),     m_y);
        check({tag, ".dir"},    int'(bus.dir),       m_dir);
        check({tag, ".tick"},   int'(bus.move_tick), m_tick);
        check({tag, ".landed"}, int'(bus.landed),    m_landed);
    endtask

    // Expected outputs at each successive move event of a full run.
    typedef struct {
        int x;
        int y;
        int dir;
        int landed;
    } ev_t;

    ev_t ev_tab[10];

    initial begin
        int ticks_seen;

        ev_tab[0] = '{14, 0, 1, 0};
        ev_tab[1] = '{18, 0, 1, 0};
        ev_tab[2] = '{20, 0, 1, 0};
        ev_tab[3] = '{20, 5, 0, 0};
        ev_tab[4] = '{16, 5, 0, 0};
        ev_tab[5] = '{12, 5, 0, 0};
        ev_tab[6] = '{ 8, 5, 0, 0};
        ev_tab[7] = '{ 4, 5, 0, 0};
        ev_tab[8] = '{ 0, 5, 0, 0};
        ev_tab[9] = '{ 0, 10, 1, 1};

        bus.start   = 1'b0;
        bus.restart = 1'b0;
        bus.en      = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #23;
        check("rst.x",      int'(bus.x_out),     XS);
        check("rst.y",      int'(bus.y_out),     YS);
        check("rst.dir",    int'(bus.dir),       1);
        check("rst.tick",   int'(bus.move_tick), 0);
        check("rst.landed", int'(bus.landed),    0);
        rst_n = 1'b1;
        @(posedge pclk);
        #1;

        // 1: idle with en high, nothing moves
        bus.en     = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            ticks_seen += int'(bus.move_tick);
        end
        check("idle.ticks", ticks_seen, 0);
        check("idle.x",     int'(bus.x_out), XS);
        check("idle.y",     int'(bus.y_out), YS);

        // 2/3: full march to landing, one move every TD clocks
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int e = 0; e < 10; e++) begin
            ticks_seen = 0;
            for (int k = 0; k < TD - 1; k++) begin
                cycle();
                ticks_seen += int'(bus.move_tick);
            end
            check($sformatf("ev%0d.early_tick", e), ticks_seen, 0);
            cycle();
            check($sformatf("ev%0d.x", e),      int'(bus.x_out),     ev_tab[e].x);
            check($sformatf("ev%0d.y", e),      int'(bus.y_out),     ev_tab[e].y);
            check($sformatf("ev%0d.dir", e),    int'(bus.dir),       ev_tab[e].dir);
            check($sformatf("ev%0d.tick", e),   int'(bus.move_tick), 1);
            check($sformatf("ev%0d.landed", e), int'(bus.landed),    ev_tab[e].landed);
        end

        // landed: frozen, start ignored
        ticks_seen = 0;
        for (int i = 0; i < 40; i++) begin
            bus.start = (i % 5 == 0);
            cycle();
            ticks_seen += int'(bus.move_tick);
        end
        bus.start = 1'b0;
        check("land.ticks",  ticks_seen, 0);
        check("land.x",      int'(bus.x_out),  0);
        check("land.y",      int'(bus.y_out),  YL);
        check("land.landed", int'(bus.landed), 1);

        // 4: pause mid-march holds position and divider
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        check("rs.landed", int'(bus.landed), 0);
        check("rs.y",      int'(bus.y_out),  YS);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        cycle();
        cycle();
        bus.en     = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            ticks_seen += int'(bus.move_tick);
        end
        check("pause.ticks", ticks_seen, 0);
        check("pause.x",     int'(bus.x_out), XS);
        bus.en = 1'b1;
        cycle();
        check("resume1.x",    int'(bus.x_out),     XS);
        check("resume1.tick", int'(bus.move_tick), 0);
        cycle();
        check("resume2.x",    int'(bus.x_out),     XS + SX);
        check("resume2.tick", int'(bus.move_tick), 1);

        // 5: restart on the same edge as a move event and a start
        cycle();
        cycle();
        cycle();
        bus.restart = 1'b1;
        bus.start   = 1'b1;
        cycle();
        bus.restart = 1'b0;
        bus.start   = 1'b0;
        check("race.x",      int'(bus.x_out),     XS);
        check("race.y",      int'(bus.y_out),     YS);
        check("race.dir",    int'(bus.dir),       1);
        check("race.tick",   int'(bus.move_tick), 0);
        check("race.landed", int'(bus.landed),    0);
        for (int i = 0; i < 2 * TD; i++) cycle();
        check("race.idle_x", int'(bus.x_out), XS);

        // 6: asynchronous reset between edges while moving
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < TD; i++) cycle();
        check("pre_arst.x",    int'(bus.x_out),     XS + SX);
        check("pre_arst.tick", int'(bus.move_tick), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.x",      int'(bus.x_out),     XS);
        check("arst.y",      int'(bus.y_out),     YS);
        check("arst.dir",    int'(bus.dir),       1);
        check("arst.tick",   int'(bus.move_tick), 0);
        check("arst.landed", int'(bus.landed),    0);
        #2;
        rst_n = 1'b1;
        cycle();
        check_model("post_arst");

        // randomized controls against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start   = ($urandom_range(0, 7) == 0);
            bus.restart = ($urandom_range(0, 63) == 0);
            bus.en      = ($urandom_range(0, 3) != 0);
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
